ssb_interp_nco: RTL and testbench

//  Parametrised sample-rate interpolator + frequency-offset NCO for the 1-bit DDS transmitter.

---
 rtl/ssb_interp_nco.sv | 162 ++++++++++++++++
 tb/tb_ssb_interp_nco.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssb_interp_nco.sv
// ssb_interp_nco
//   Sample-rate interpolator plus frequency-offset NCO for the 1-bit DDS transmitter.
//   Signed offset samples arrive on a valid/ready stream into a one-entry slot. At each
//   sample boundary the interpolator snaps to the previous target and starts a linear ramp
//   towards the new sample. The ramp is added to a runtime carrier increment, and the
//   phase MSBs are emitted as RF while the VOX hang timer keeps the transmitter active.
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en_i         transmitter enable; low clears the sample path and VOX state
//   carrier_i    carrier phase increment, sampled every clock
//   s_data_i     signed offset sample
//   s_valid_i    sample valid
//   s_ready_o    sample ready (slot empty, enabled, not in reset)
//   rf_o         registered RF output (phase MSBs, zero when not transmitting)
//   phase_o      phase accumulator
//   tx_active_o  VOX transmit state
//   tick_o       one-cycle pulse at each sample boundary
//   underrun_o   one-cycle pulse at a boundary with no usable sample while transmitting
module ssb_interp_nco #(
   parameter int unsigned SAMPLE_W      = 32,
   parameter int unsigned PHASE_W       = 32,
   parameter int unsigned FRAC_W        = 16,
   parameter int unsigned INTERP_PERIOD = 2083,
   parameter int unsigned STEP_SHIFT    = 10,
   parameter logic [15:0] STEP_MUL      = 16'd32217,
   parameter int unsigned HANG_CYCLES   = 20000000,
   parameter int unsigned OUT_W         = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic [PHASE_W-1:0]  carrier_i,
   input  logic [SAMPLE_W-1:0] s_data_i,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   output logic [OUT_W-1:0]    rf_o,
   output logic [PHASE_W-1:0]  phase_o,
   output logic                tx_active_o,
   output logic                tick_o,
   output logic                underrun_o
);

   localparam int unsigned CNT_W  = $clog2(INTERP_PERIOD);
   localparam int unsigned ACC_W  = SAMPLE_W + FRAC_W;
   localparam int unsigned DIFF_W = SAMPLE_W + 1;
   // Wide enough for diff * 17-bit signed multiplier and for the truncation to ACC_W.
   localparam int unsigned PROD_W = ACC_W + 18;
   localparam int unsigned HANG_W = $clog2(HANG_CYCLES + 1);

   logic [CNT_W-1:0]           cnt;
   logic                       tick;
   logic                       accept;
   logic signed [SAMPLE_W-1:0] nxt;
   logic signed [SAMPLE_W-1:0] target;
   logic                       nxt_valid;
   logic [1:0]                 ok_pipe;
   logic                       step_ok;
   logic signed [DIFF_W-1:0]   diff;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    step_pre;
   logic signed [ACC_W-1:0]    step;
   logic signed [ACC_W-1:0]    acc;
   logic signed [SAMPLE_W-1:0] interp;
   logic [PHASE_W-1:0]         inc;
   logic [PHASE_W-1:0]         phase;
   logic [HANG_W-1:0]          hang;
   logic                       tx_active;

   assign tick      = (cnt == CNT_W'(INTERP_PERIOD - 1));
   assign s_ready_o = en_i & ~nxt_valid & ~rst;
   assign accept    = s_valid_i & s_ready_o;

   assign prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, STEP_MUL}));
   // Integer part of the interpolator accumulator; fractional bits simply floor away.
   assign interp = acc[ACC_W-1 -: SAMPLE_W];

   assign phase_o     = phase;
   assign tx_active_o = tx_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         tick_o     <= 1'b0;
         nxt        <= '0;
         target     <= '0;
         nxt_valid  <= 1'b0;
         ok_pipe    <= '0;
         step_ok    <= 1'b0;
         diff       <= '0;
         step_pre   <= '0;
         step       <= '0;
         acc        <= '0;
         inc        <= '0;
         phase      <= '0;
         hang       <= '0;
         tx_active  <= 1'b0;
         rf_o       <= '0;
         underrun_o <= 1'b0;
      end else begin
         cnt        <= tick ? '0 : cnt + CNT_W'(1);
         tick_o     <= tick;
         underrun_o <= 1'b0;

         // Step pipeline runs freely; step_ok marks when step_pre reflects the slot.
         diff     <= DIFF_W'(nxt) - DIFF_W'(target);
         step_pre <= ACC_W'(prod >>> STEP_SHIFT);

         // Carrier plus offset, then accumulate; runs regardless of transmit state.
         inc   <= carrier_i + PHASE_W'(interp);
         phase <= phase + inc;
         rf_o  <= tx_active ? phase[PHASE_W-1 -: OUT_W] : '0;

         if (!en_i) begin
            nxt_valid <= 1'b0;
            ok_pipe   <= '0;
            step_ok   <= 1'b0;
            target    <= '0;
            step      <= '0;
            acc       <= '0;
            hang      <= '0;
            tx_active <= 1'b0;
         end else begin
            ok_pipe <= {ok_pipe[0], accept};
            if (ok_pipe[1]) begin
               step_ok <= 1'b1;
            end
            if (accept) begin
               nxt       <= s_data_i;
               nxt_valid <= 1'b1;
            end

            if (tick) begin
               // Snap to where the previous ramp should have landed.
               acc <= {target, {FRAC_W{1'b0}}};
               if (nxt_valid && step_ok) begin
                  target    <= nxt;
                  step      <= step_pre;
                  nxt_valid <= 1'b0;
                  step_ok   <= 1'b0;
               end else begin
                  step       <= '0;
                  underrun_o <= tx_active;
               end
            end else begin
               acc <= acc + step;
            end

            // A fresh sample reloads the hang timer even as it expires.
            if (accept) begin
               hang      <= HANG_W'(HANG_CYCLES);
               tx_active <= 1'b1;
            end else if (hang != '0) begin
               hang <= hang - HANG_W'(1);
            end else begin
               tx_active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ssb_interp_nco.sv
// tb_ssb_interp_nco
//   Directed bench for ssb_interp_nco with a short period (8 clocks), 4 fractional bits,
//   a 20-clock hang time and 2 RF bits. Expected values are hand-derived constants.
module tb_ssb_interp_nco;

   localparam int unsigned SW = 32;
   localparam int unsigned PW = 32;
   localparam int unsigned OW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [PW-1:0] carrier;
   logic [SW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [OW-1:0] rf;
   logic [PW-1:0] phase;
   logic          tx_active;
   logic          tick;
   logic          underrun;

   int            checks = 0;
   int            errors = 0;
   int            n = 0;
   int            accepts;
   logic [PW-1:0] last_phase = '0;
   logic [PW-1:0] dphase = '0;

   always #5 clk = ~clk;

   ssb_interp_nco #(
      .SAMPLE_W     (SW),
      .PHASE_W      (PW),
      .FRAC_W       (4),
      .INTERP_PERIOD(8),
      .STEP_SHIFT   (10),
      .STEP_MUL     (16'd2048),
      .HANG_CYCLES  (20),
      .OUT_W        (OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .carrier_i  (carrier),
      .s_data_i   (s_data),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .rf_o       (rf),
      .phase_o    (phase),
      .tx_active_o(tx_active),
      .tick_o     (tick),
      .underrun_o (underrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   // One clock; n counts edges since the last reset edge. Outputs are read 1 time unit
   // after the edge, and the per-edge phase increment is tracked.
   task automatic tick_clk();
      logic was_rst;
      was_rst = rst;
      @(posedge clk);
      #1;
      if (was_rst) n = 0;
      else n = n + 1;
      chk("tick", 64'(tick), 64'((n != 0) && (n % 8 == 0)));
      dphase     = phase - last_phase;
      last_phase = phase;
   endtask

   task automatic run_to(input int t);
      while (n < t) tick_clk();
   endtask

   int            ramp_exp [8] = '{0, 0, 1, 1, 2, 3, 3, 4};
   int            neg_exp  [6] = '{32767, 24575, 16383, 8191, -1, 0};
   logic [PW-1:0] e32;

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      carrier = '0;
      s_data  = '0;
      s_valid = 1'b0;
      tick_clk();
      tick_clk();
      chk("rst_phase", 64'(phase), 64'(0));
      chk("rst_tx", 64'(tx_active), 64'(0));
      chk("rst_rf", 64'(rf), 64'(0));
      chk("rst_underrun", 64'(underrun), 64'(0));
      chk("rst_ready", 64'(s_ready), 64'(0));

      // Carrier only, no samples.
      rst     = 1'b0;
      en      = 1'b1;
      carrier = 32'h4000_0000;
      #1;
      chk("ready_after_rst", 64'(s_ready), 64'(1));
      for (int i = 1; i <= 9; i++) begin
         tick_clk();
         e32 = 32'(n - 1) << 30;
         chk("carrier_phase", 64'(phase), 64'(e32));
         chk("idle_tx", 64'(tx_active), 64'(0));
         chk("idle_rf", 64'(rf), 64'(0));
         chk("idle_underrun", 64'(underrun), 64'(0));
      end

      // Single zero sample: VOX hang, RF gating, underrun at the following boundary.
      s_valid = 1'b1;
      s_data  = '0;
      tick_clk();
      s_valid = 1'b0;
      chk("vox_on", 64'(tx_active), 64'(1));
      chk("slot_full", 64'(s_ready), 64'(0));
      chk("rf_gated", 64'(rf), 64'(0));
      tick_clk();
      chk("rf_11", 64'(rf), 64'(1));
      tick_clk();
      chk("rf_12", 64'(rf), 64'(2));
      tick_clk();
      chk("rf_13", 64'(rf), 64'(3));
      run_to(16);
      chk("consumed_ready", 64'(s_ready), 64'(1));
      chk("no_underrun_16", 64'(underrun), 64'(0));
      run_to(24);
      chk("underrun_24", 64'(underrun), 64'(1));
      tick_clk();
      chk("underrun_pulse", 64'(underrun), 64'(0));
      run_to(29);
      chk("hang_29", 64'(tx_active), 64'(1));
      run_to(31);
      chk("hang_done", 64'(tx_active), 64'(0));
      run_to(32);
      chk("rf_off", 64'(rf), 64'(0));
      chk("no_underrun_idle", 64'(underrun), 64'(0));
      chk("phase_32", 64'(phase), 64'(32'hC000_0000));

      // Valid held high: one accept per period.
      s_valid = 1'b1;
      accepts = 0;
      while (n < 56) begin
         if (s_ready) accepts++;
         if (n == 36) chk("ready_low_full", 64'(s_ready), 64'(0));
         tick_clk();
         if (n % 8 == 0) chk("held_no_underrun", 64'(underrun), 64'(0));
      end
      s_valid = 1'b0;
      chk("accept_count", 64'(accepts), 64'(3));

      // Fine ramp 0 -> 5 with zero carrier; phase increments follow interp two clocks late.
      carrier = '0;
      run_to(64);
      chk("underrun_64", 64'(underrun), 64'(1));
      s_valid = 1'b1;
      s_data  = 32'd5;
      tick_clk();
      s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         run_to(74 + k);
         e32 = 32'(ramp_exp[k]);
         chk("ramp", 64'(dphase), 64'(e32));
         if (n == 80) chk("underrun_80", 64'(underrun), 64'(1));
      end
      s_valid = 1'b1;
      s_data  = 32'd32767;
      tick_clk();
      s_valid = 1'b0;
      chk("hold_5", 64'(dphase), 64'(32'd5));
      run_to(88);
      chk("no_underrun_88", 64'(underrun), 64'(0));
      s_valid = 1'b1;
      s_data  = 32'hFFFF_8000;
      tick_clk();
      s_valid = 1'b0;
      run_to(96);
      chk("no_underrun_96", 64'(underrun), 64'(0));

      // Negative ramp 32767 -> -32768, disabled mid-ramp.
      for (int k = 0; k < 6; k++) begin
         run_to(98 + k);
         e32 = 32'(neg_exp[k]);
         chk("neg_ramp", 64'(dphase), 64'(e32));
         if (n == 100) en = 1'b0;
      end
      chk("dis_tx", 64'(tx_active), 64'(0));
      chk("dis_ready", 64'(s_ready), 64'(0));
      run_to(104);
      chk("dis_no_underrun", 64'(underrun), 64'(0));
      chk("dis_rf", 64'(rf), 64'(0));

      // Reset with a sample in flight.
      run_to(105);
      en = 1'b1;
      tick_clk();
      s_valid = 1'b1;
      s_data  = 32'd80;
      tick_clk();
      s_valid = 1'b0;
      chk("reaccept_tx", 64'(tx_active), 64'(1));
      rst = 1'b1;
      tick_clk();
      chk("mid_rst_tx", 64'(tx_active), 64'(0));
      chk("mid_rst_phase", 64'(phase), 64'(0));
      chk("mid_rst_rf", 64'(rf), 64'(0));
      chk("mid_rst_ready", 64'(s_ready), 64'(0));
      rst = 1'b0;
      tick_clk();
      chk("dropped_ready", 64'(s_ready), 64'(1));
      chk("dropped_tx", 64'(tx_active), 64'(0));
      run_to(16);
      chk("dropped_phase", 64'(phase), 64'(0));
      chk("dropped_underrun", 64'(underrun), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
